hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports id_rs, id_rt  in  5 each  source register fields of the instruction in the IF/ID latch.
REQ-004 SHALL have port id_uses_rt  in  1  decoded instruction reads rt as an operand.
REQ-005 SHALL have ports ex_memread  in  1 and ex_regdest  in  5  load flag and destination of the instruction in the ID/EX latch.
REQ-006 SHALL have ports mem_dren, mem_dwen  in  1 each  data-memory read/write request of the instruction in the EX/MEM latch.
REQ-007 SHALL have ports ihit, dhit  in  1 each  instruction/data memory completion.
REQ-008 SHALL have ports mem_branch_taken, mem_halt  in  1 each  redirect and halt resolved in MEM.
REQ-009 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables.
REQ-010 SHALL have outputs ifid_flush, idex_flush, exmem_flush  out  1 each  load-bubble into that latch.
REQ-011 SHALL have outputs halt_o, dwait_o  out  1 each  halted / data-wait status.
REQ-012 SHALL have outputs stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-013 SHALL implement FSM states RUN, DMEM_WAIT, HALTED; control outputs are combinational from state and inputs.
REQ-014 SHALL define pending = mem_dren | mem_dwen; loaduse = ex_memread & ex_regdest!=0 & (ex_regdest==id_rs | (id_uses_rt & ex_regdest==id_rt)).
REQ-015 SHALL evaluate in RUN/DMEM_WAIT with priority: halt > data wait > branch > load-use > ifetch miss > normal.
REQ-016 halt: mem_halt=1 -> all enables 0, all flushes 0, next state HALTED.
REQ-017 data wait: pending & !dhit -> all enables 0, all flushes 0, dwait_o=1, next state DMEM_WAIT.
REQ-018 DMEM_WAIT: stays while pending & !dhit; dhit=1 -> lower priorities evaluated that same cycle, next state RUN.
REQ-019 branch: mem_branch_taken=1 (no wait) -> all enables 1, ifid_flush=idex_flush=exmem_flush=1; load-use and ihit ignored that cycle.
REQ-020 load-use: pc_en=0, ifid_en=0, idex_flush=1, idex_en=exmem_en=memwb_en=1; exactly one bubble per hazard.
REQ-021 ifetch miss: ihit=0 -> pc_en=0, ifid_flush=1, downstream enables 1.
REQ-022 normal: all enables 1, all flushes 0.
REQ-023 HALTED: all enables 0, flushes 0, halt_o=1; exit only by reset.
REQ-024 stall_cnt SHALL increment each cycle with pc_en=0 outside HALTED, saturating at 16'hFFFF.
REQ-025 flush_cnt SHALL increment each cycle REQ-019 applies, saturating at 16'hFFFF.
REQ-026 A flush and enable on the same latch SHALL mean bubble is loaded; flush wins.

Reset
REQ-027 nRST=0 SHALL force state RUN, stall_cnt=0, flush_cnt=0 immediately, independent of CLK.
REQ-028 During reset all enables, flushes, halt_o, dwait_o SHALL be 0.
REQ-029 Reset mid-DMEM_WAIT or HALTED SHALL return to RUN with counters cleared.

Structure
REQ-030 hazard_state_t enum (RUN, DMEM_WAIT, HALTED) SHALL live in cpu_types_pkg.
REQ-031 Counter width 16 SHALL be a package constant.
REQ-032 One sub-module sat_counter (parameterised width, inc, saturate) SHALL be instantiated twice.

Verification
REQ-033 Load-use: ex_memread=1, ex_regdest=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 one cycle; stall_cnt=1.
REQ-034 Data wait: mem_dren=1, dhit=0 for 3 cycles then 1 -> dwait_o=1 and all enables 0 for 3 cycles, all 1 on dhit cycle; stall_cnt=3.
REQ-035 Branch during load-use: mem_branch_taken=1 plus load-use condition -> all enables 1, three flushes 1; flush_cnt=1.
REQ-036 Halt: mem_halt=1 -> next cycle halt_o=1, enables 0 indefinitely; nRST pulse -> RUN, counters 0.
REQ-037 Zero register: ex_memread=1, ex_regdest=0, id_rs=0 -> no stall, pc_en=1.
REQ-038 Saturation: force 65536 ihit=0 cycles -> stall_cnt=16'hFFFF, holds.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipeline hazard control logic.
package cpu_types_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      DMEM_WAIT = 2'd1,
      HALTED    = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-unit signal bundle: latch status in, latch advance/flush control out.
interface hazard_if;
   import cpu_types_pkg::*;

   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_memread;
   logic [4:0]       ex_regdest;
   logic             mem_dren;
   logic             mem_dwen;
   logic             ihit;
   logic             dhit;
   logic             mem_branch_taken;
   logic             mem_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             halt_o;
   logic             dwait_o;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   hazard_state_t    dbg_state;

   // Handshake: there is none; every output is a level qualified only by the
   // current cycle, and the pipeline samples it on the next rising clock edge.
   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_memread, ex_regdest,
             mem_dren, mem_dwen, ihit, dhit, mem_branch_taken, mem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halt_o, dwait_o,
             stall_cnt, flush_cnt, dbg_state
   );

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_memread, ex_regdest,
             mem_dren, mem_dwen, ihit, dhit, mem_branch_taken, mem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halt_o, dwait_o,
             stall_cnt, flush_cnt, dbg_state
   );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Five-stage pipeline hazard control: halt, data-memory wait, branch flush,
// load-use bubble and ifetch-miss stall, with stall/flush performance counters.
module hazard_control_unit
   import cpu_types_pkg::*;
(
   input  logic CLK,
   input  logic nRST,
   hazard_if.slave hz
);

   hazard_state_t r_state;
   hazard_state_t w_next_state;

   logic w_pending;
   logic w_loaduse;
   logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
   logic w_ifid_flush, w_idex_flush, w_exmem_flush;
   logic w_halt, w_dwait;
   logic w_stall_inc, w_flush_inc;
   logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

   assign w_pending = hz.mem_dren | hz.mem_dwen;
   // Register 0 is hard-wired, so a load targeting it can never create a hazard.
   assign w_loaduse = hz.ex_memread && (hz.ex_regdest != 5'd0) &&
                      ((hz.ex_regdest == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_regdest == hz.id_rt)));

   always_comb begin
      w_next_state  = r_state;
      w_pc_en       = 1'b0;
      w_ifid_en     = 1'b0;
      w_idex_en     = 1'b0;
      w_exmem_en    = 1'b0;
      w_memwb_en    = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_flush = 1'b0;
      w_halt        = 1'b0;
      w_dwait       = 1'b0;
      w_flush_inc   = 1'b0;
      if (!nRST) begin
         w_next_state = RUN;
      end else if (r_state == HALTED) begin
         w_halt = 1'b1;
      end else if (hz.mem_halt) begin
         w_next_state = HALTED;
      end else if (w_pending && !hz.dhit) begin
         w_dwait      = 1'b1;
         w_next_state = DMEM_WAIT;
      end else begin
         // Wait resolved (or never started): fall through the lower priorities.
         w_next_state = RUN;
         w_pc_en      = 1'b1;
         w_ifid_en    = 1'b1;
         w_idex_en    = 1'b1;
         w_exmem_en   = 1'b1;
         w_memwb_en   = 1'b1;
         if (hz.mem_branch_taken) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_flush_inc   = 1'b1;
         end else if (w_loaduse) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
         end else if (!hz.ihit) begin
            w_pc_en      = 1'b0;
            w_ifid_flush = 1'b1;
         end
      end
   end

   assign w_stall_inc = nRST && (r_state != HALTED) && !w_pc_en;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .i_clk   (CLK),
      .i_rst_n (nRST),
      .i_inc   (w_stall_inc),
      .o_count (w_stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .i_clk   (CLK),
      .i_rst_n (nRST),
      .i_inc   (w_flush_inc),
      .o_count (w_flush_cnt)
   );

   assign hz.pc_en       = w_pc_en;
   assign hz.ifid_en     = w_ifid_en;
   assign hz.idex_en     = w_idex_en;
   assign hz.exmem_en    = w_exmem_en;
   assign hz.memwb_en    = w_memwb_en;
   assign hz.ifid_flush  = w_ifid_flush;
   assign hz.idex_flush  = w_idex_flush;
   assign hz.exmem_flush = w_exmem_flush;
   assign hz.halt_o      = w_halt;
   assign hz.dwait_o     = w_dwait;
   assign hz.stall_cnt   = w_stall_cnt;
   assign hz.flush_cnt   = w_flush_cnt;
   assign hz.dbg_state   = r_state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;
   import cpu_types_pkg::*;

   // Control vector bit order: pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, halt, dwait
   localparam logic [9:0] C_NORMAL  = 10'b11111_000_00;
   localparam logic [9:0] C_LOADUSE = 10'b00111_010_00;
   localparam logic [9:0] C_BRANCH  = 10'b11111_111_00;
   localparam logic [9:0] C_IMISS   = 10'b01111_100_00;
   localparam logic [9:0] C_WAIT    = 10'b00000_000_01;
   localparam logic [9:0] C_HALTED  = 10'b00000_000_10;
   localparam logic [9:0] C_ZERO    = 10'b00000_000_00;

   logic clk;
   logic nrst;
   int   n_vec;
   int   n_miss;

   hazard_if hz ();

   hazard_control_unit dut (
      .CLK  (clk),
      .nRST (nrst),
      .hz   (hz.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [9:0] ctl();
      return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
              hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.halt_o, hz.dwait_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      hz.id_rs = 5'd0;
      hz.id_rt = 5'd0;
      hz.id_uses_rt = 1'b0;
      hz.ex_memread = 1'b0;
      hz.ex_regdest = 5'd0;
      hz.mem_dren = 1'b0;
      hz.mem_dwen = 1'b0;
      hz.ihit = 1'b1;
      hz.dhit = 1'b0;
      hz.mem_branch_taken = 1'b0;
      hz.mem_halt = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      nrst = 1'b0;
      tick();
      nrst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      nrst = 1'b1;
      #2;
      nrst = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_ZERO) begin
         n_miss++;
         $display("FAIL reset_ctl got %b want %b", ctl(), C_ZERO);
      end
      n_vec++;
      if (hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0 || hz.dbg_state !== RUN) begin
         n_miss++;
         $display("FAIL reset_state got stall=%0d flush=%0d st=%0d want 0 0 0",
                  hz.stall_cnt, hz.flush_cnt, hz.dbg_state);
      end
      tick();
      nrst = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL post_reset_normal got %b want %b", ctl(), C_NORMAL);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      hz.ex_memread = 1'b1;
      hz.ex_regdest = 5'd5;
      hz.id_rs = 5'd5;
      #1;
      n_vec++;
      if (ctl() !== C_LOADUSE) begin
         n_miss++;
         $display("FAIL loaduse_rs got %b want %b", ctl(), C_LOADUSE);
      end
      tick();
      hz.ex_memread = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL || hz.stall_cnt !== 16'd1) begin
         n_miss++;
         $display("FAIL loaduse_bubble_once got %b stall=%0d want %b stall=1",
                  ctl(), hz.stall_cnt, C_NORMAL);
      end
      hz.ex_memread = 1'b1;
      hz.id_rs = 5'd3;
      hz.id_rt = 5'd5;
      hz.id_uses_rt = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL loaduse_rt_unused got %b want %b", ctl(), C_NORMAL);
      end
      hz.id_uses_rt = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_LOADUSE) begin
         n_miss++;
         $display("FAIL loaduse_rt got %b want %b", ctl(), C_LOADUSE);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (hz.stall_cnt !== 16'd2) begin
         n_miss++;
         $display("FAIL loaduse_stall_cnt got %0d want 2", hz.stall_cnt);
      end
   endtask

   task automatic test_zero_reg();
      apply_reset();
      hz.ex_memread = 1'b1;
      hz.ex_regdest = 5'd0;
      hz.id_rs = 5'd0;
      hz.id_rt = 5'd0;
      hz.id_uses_rt = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL zero_reg got %b want %b", ctl(), C_NORMAL);
      end
   endtask

   task automatic test_imiss();
      apply_reset();
      hz.ihit = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_IMISS) begin
         n_miss++;
         $display("FAIL imiss got %b want %b", ctl(), C_IMISS);
      end
      tick();
      hz.ihit = 1'b1;
      #1;
      n_vec++;
      if (hz.stall_cnt !== 16'd1 || ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL imiss_recover got %b stall=%0d want %b stall=1",
                  ctl(), hz.stall_cnt, C_NORMAL);
      end
   endtask

   task automatic test_dwait();
      apply_reset();
      hz.mem_dren = 1'b1;
      hz.dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++;
         if (ctl() !== C_WAIT) begin
            n_miss++;
            $display("FAIL dwait_cycle%0d got %b want %b", i, ctl(), C_WAIT);
         end
         tick();
      end
      n_vec++;
      if (hz.dbg_state !== DMEM_WAIT) begin
         n_miss++;
         $display("FAIL dwait_state got %0d want %0d", hz.dbg_state, DMEM_WAIT);
      end
      hz.dhit = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL dwait_hit got %b want %b", ctl(), C_NORMAL);
      end
      tick();
      hz.mem_dren = 1'b0;
      #1;
      n_vec++;
      if (hz.dbg_state !== RUN || hz.stall_cnt !== 16'd3) begin
         n_miss++;
         $display("FAIL dwait_done got st=%0d stall=%0d want st=0 stall=3",
                  hz.dbg_state, hz.stall_cnt);
      end
      hz.mem_dwen = 1'b1;
      hz.dhit = 1'b0;
      tick();
      nrst = 1'b0;
      #1;
      n_vec++;
      if (hz.dbg_state !== RUN || hz.stall_cnt !== 16'd0 || ctl() !== C_ZERO) begin
         n_miss++;
         $display("FAIL dwait_reset got st=%0d stall=%0d ctl=%b want 0 0 %b",
                  hz.dbg_state, hz.stall_cnt, ctl(), C_ZERO);
      end
      idle_inputs();
      tick();
      nrst = 1'b1;
      #1;
   endtask

   task automatic test_branch();
      apply_reset();
      hz.mem_branch_taken = 1'b1;
      hz.ex_memread = 1'b1;
      hz.ex_regdest = 5'd5;
      hz.id_rs = 5'd5;
      hz.ihit = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_BRANCH) begin
         n_miss++;
         $display("FAIL branch_over_loaduse got %b want %b", ctl(), C_BRANCH);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (hz.flush_cnt !== 16'd1 || hz.stall_cnt !== 16'd0) begin
         n_miss++;
         $display("FAIL branch_counts got flush=%0d stall=%0d want 1 0",
                  hz.flush_cnt, hz.stall_cnt);
      end
      hz.mem_branch_taken = 1'b1;
      hz.mem_dren = 1'b1;
      hz.dhit = 1'b0;
      #1;
      n_vec++;
      if (ctl() !== C_WAIT) begin
         n_miss++;
         $display("FAIL wait_over_branch got %b want %b", ctl(), C_WAIT);
      end
      tick();
      hz.dhit = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_BRANCH) begin
         n_miss++;
         $display("FAIL branch_on_dhit got %b want %b", ctl(), C_BRANCH);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if (hz.flush_cnt !== 16'd2 || hz.stall_cnt !== 16'd1) begin
         n_miss++;
         $display("FAIL branch_wait_counts got flush=%0d stall=%0d want 2 1",
                  hz.flush_cnt, hz.stall_cnt);
      end
   endtask

   task automatic test_halt();
      apply_reset();
      hz.ihit = 1'b0;
      tick();
      tick();
      hz.ihit = 1'b1;
      hz.mem_halt = 1'b1;
      hz.mem_branch_taken = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_ZERO) begin
         n_miss++;
         $display("FAIL halt_cycle got %b want %b", ctl(), C_ZERO);
      end
      tick();
      hz.mem_halt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_vec++;
         if (ctl() !== C_HALTED || hz.dbg_state !== HALTED) begin
            n_miss++;
            $display("FAIL halted_hold%0d got %b st=%0d want %b st=2",
                     i, ctl(), hz.dbg_state, C_HALTED);
         end
         tick();
      end
      n_vec++;
      if (hz.stall_cnt !== 16'd3 || hz.flush_cnt !== 16'd0) begin
         n_miss++;
         $display("FAIL halt_counts got stall=%0d flush=%0d want 3 0",
                  hz.stall_cnt, hz.flush_cnt);
      end
      nrst = 1'b0;
      #1;
      n_vec++;
      if (hz.dbg_state !== RUN || hz.stall_cnt !== 16'd0 || hz.flush_cnt !== 16'd0) begin
         n_miss++;
         $display("FAIL halt_reset got st=%0d stall=%0d flush=%0d want 0 0 0",
                  hz.dbg_state, hz.stall_cnt, hz.flush_cnt);
      end
      idle_inputs();
      tick();
      nrst = 1'b1;
      #1;
      n_vec++;
      if (ctl() !== C_NORMAL) begin
         n_miss++;
         $display("FAIL halt_exit got %b want %b", ctl(), C_NORMAL);
      end
   endtask

   task automatic test_saturation();
      apply_reset();
      hz.ihit = 1'b0;
      repeat (65534) tick();
      n_vec++;
      if (hz.stall_cnt !== 16'hFFFE) begin
         n_miss++;
         $display("FAIL sat_before got %h want fffe", hz.stall_cnt);
      end
      repeat (2) tick();
      n_vec++;
      if (hz.stall_cnt !== 16'hFFFF) begin
         n_miss++;
         $display("FAIL sat_reach got %h want ffff", hz.stall_cnt);
      end
      repeat (3) tick();
      n_vec++;
      if (hz.stall_cnt !== 16'hFFFF) begin
         n_miss++;
         $display("FAIL sat_hold got %h want ffff", hz.stall_cnt);
      end
      idle_inputs();
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      nrst   = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_zero_reg();
      test_imiss();
      test_dwait();
      test_branch();
      test_halt();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
